mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data port, alongside dmem (downstream consumer of MemWrite/DataAdr/WriteData).
- Store to TXDATA queues a byte in a small FIFO; a serialiser shifts bytes out 8N1, LSB first, on `tx`.
- The top muxes `rd` into ReadData when `sel` is high; dmem write enable is gated with `~sel`.

Parameters:
- BASE_ADDR, 32'h00000080, 16-byte aligned register window base.
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  store strobe (MemWrite).
- a  input  32  byte address (DataAdr).
- wd  input  32  store data (WriteData).
- rd  output  32  register read data, combinational.
- sel  output  1  high when a[31:4] == BASE_ADDR[31:4].
- tx  output  1  serial line, idles high.

Behaviour:
- Decode is combinational: sel = (a[31:4] == BASE_ADDR[31:4]); register offset = a[3:2]; a[1:0] ignored.
- Offset 0, TXDATA:
  - write with FIFO not full pushes wd[7:0];
  - write with FIFO full drops the byte and sets the sticky `ovf` flag;
  - reads return 0.
- Offset 1, STATUS:
  - read = {28'b0, ovf, busy, full, empty}; busy = FSM not IDLE;
  - any write clears ovf. If set and clear happen in the same cycle, clear wins.
- Offsets 2 and 3: read 0, writes ignored.
- `rd` is valid only while sel is high; it is 0 when sel is low.
- Writes take effect at posedge clk when we & sel.
- FSM states: IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If FIFO not empty at the edge: pop head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO not empty, pop and go directly to START (back-to-back frames, no extra idle cycle); else go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles.
- Latency: a push into an empty FIFO while IDLE makes tx fall 2 cycles after the write edge (push edge, then pop edge; tx low after the pop edge).
- tx is driven from a register (glitch-free).
- Push and pop in the same cycle:
  - FIFO not full: both happen, count unchanged.
  - FIFO full: push is dropped and ovf is set, even if a pop occurs.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
- Reset (synchronous, any time, including mid-frame):
  - FSM=IDLE, tx=1 from the next edge;
  - FIFO emptied (pointers and count = 0);
  - ovf=0; shift register and counters = 0.
  - Reset values: empty=1, full=0, busy=0. `rd` and `sel` are combinational functions of `a` and state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- When undefined: no PARITY state; frame is 8N1 as above.

Decomposition:
- Package `uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, DATA, PARITY, STOP} (PARITY always declared);
  - localparams OFF_TXDATA=2'd0, OFF_STATUS=2'd1;
  - STATUS bit indices.
- Sub-module `sync_fifo` (WIDTH, DEPTH): push/pop/din/dout/full/empty, synchronous reset. The FIFO storage lives there; the FSM and decode live in mmio_uart_tx.

Test Plan:
- Reset check: assert reset 2 cycles -> tx=1, and STATUS read at 0x84 returns 32'h1 (empty).
- Single byte (CLKS_PER_BIT=4): store 32'h000000A5 to 0x80 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. STATUS reads busy=1 during the frame and 32'h1 after 40 cycles.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles -> two frames with no idle cycle between them; total 80 cycles from the first start bit to the end of the second stop bit.
- Overflow: with the serialiser busy, store 5 bytes (DEPTH=4) -> last store dropped; STATUS = 32'hE (ovf, busy, full). Write to 0x84 -> ovf cleared; exactly 5 frames are sent (1 in flight + 4 queued).
- Decode: store to 0x88, 0x7C and 0x90 -> no FIFO change, sel=0 for 0x7C and 0x90, sel=1 with rd=0 for 0x88.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 at the next edge, STATUS=32'h1, and no residual frame is transmitted afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the MMIO UART transmitter.
package uart_pkg;

  // PARITY is always declared so the encoding does not depend on the build.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, TX FIFO and serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BaudMax = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [1:0] off;
  logic       wr_en, push_req, clr_ovf;
  logic       fifo_full, fifo_empty, pop, do_load, baud_done;
  logic [7:0] fifo_dout;
  logic [3:0] status;
  logic       unused_bits;

  assign sel         = (a[31:4] == BASE_ADDR[31:4]);
  assign off         = a[3:2];
  assign wr_en       = we & sel;
  assign push_req    = wr_en & (off == OFF_TXDATA);
  assign clr_ovf     = wr_en & (off == OFF_STATUS);
  assign baud_done   = (baud_q == BaudMax);
  assign tx          = tx_q;
  assign unused_bits = ^{a[1:0], wd[31:8]};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_req),
    .pop  (pop),
    .din  (wd[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A push into a full FIFO is dropped even when a pop happens in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (clr_ovf)               ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    do_load = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: do_load = ~fifo_empty;
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else baud_d = baud_q + BW'(1);
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + BW'(1);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = STOP;
        end else baud_d = baud_q + BW'(1);
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
          do_load = ~fifo_empty;
        end else baud_d = baud_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Loading from STOP chains frames with no idle cycle in between.
    if (do_load) begin
      pop     = 1'b1;
      shift_d = fifo_dout;
      baud_d  = '0;
      bit_d   = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = (state_q != IDLE);
    status[ST_OVF]   = ovf_q;
    rd = '0;
    if (sel && off == OFF_STATUS) rd = {28'b0, status};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, we, sel, tx;
  logic [31:0] a, wd, rd;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0080),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .sel  (sel),
    .tx   (tx)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    a  = 32'h0;
  endtask

  task automatic status_chk(input string name, input logic [31:0] exp);
    a = 32'h84;
    #1;
    chk(name, rd, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks one whole frame cycle by cycle; leaves time at the negedge just after the frame.
  task automatic check_frame(input string name, input logic [7:0] b, input bit wait_start,
                             input logic [31:0] exp_mid, output int lat);
    logic bad;
    lat = 0;
    if (wait_start) begin
      @(negedge clk);
      lat = 1;
      while (tx !== 1'b0 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
    end
    chk({name, " start"}, {31'b0, tx}, 32'h0);
    if (tx !== 1'b0) return;
    for (int i = 0; i < NBITS; i++) begin
      bad = 1'b0;
      for (int k = 0; k < C; k++) begin
        if (tx !== frame_bit(b, i)) bad = 1'b1;
        if (i == 5 && k == 0) status_chk({name, " mid status"}, exp_mid);
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d bad-cycles", name, i), {31'b0, bad}, 32'h0);
    end
  endtask

  task automatic idle_chk(input string name, input int n);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk(name, {31'b0, bad}, 32'h0);
  endtask

  initial begin
    int lat;
    int s;

    vecs[0] = '{1'b0, 32'h84, 32'h0,  1'b1, 32'h1};
    vecs[1] = '{1'b0, 32'h80, 32'h0,  1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'h88, 32'h0,  1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h8C, 32'h0,  1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h88, 32'hFF, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h7C, 32'hAB, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h90, 32'hCD, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h86, 32'h0,  1'b1, 32'h1};
    vecs[8] = '{1'b0, 32'h7C, 32'h0,  1'b0, 32'h0};
    vecs[9] = '{1'b0, 32'h1084, 32'h0, 1'b0, 32'h0};

    reset = 1'b1;
    we    = 1'b0;
    a     = 32'h0;
    wd    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tx", {31'b0, tx}, 32'h1);
    status_chk("reset status", 32'h1);
    reset = 1'b0;

    // Single byte: tx falls on the second sampled negedge after the write edge.
    write(32'h80, 32'h0000_00A5);
    check_frame("a5", 8'hA5, 1'b1, 32'h5, lat);
    chk("a5 latency", lat, 32'd2);
    chk("a5 tx after", {31'b0, tx}, 32'h1);
    status_chk("a5 status after", 32'h1);

    // Back-to-back frames: no idle cycle between them.
    write(32'h80, 32'h55);
    write(32'h80, 32'h0F);
    check_frame("b2b 55", 8'h55, 1'b1, 32'h4, lat);
    s = cyc - NBITS * C;
    check_frame("b2b 0f", 8'h0F, 1'b0, 32'h5, lat);
    chk("b2b total cycles", cyc - s, 2 * NBITS * C);
    chk("b2b tx after", {31'b0, tx}, 32'h1);
    status_chk("b2b status after", 32'h1);

    // Overflow: one frame in flight, five stores, last one dropped.
    write(32'h80, 32'h11);
    @(negedge clk);
    @(negedge clk);
    s = cyc;
    chk("ovf in-flight start", {31'b0, tx}, 32'h0);
    write(32'h80, 32'h22);
    write(32'h80, 32'h33);
    write(32'h80, 32'h44);
    write(32'h80, 32'h55);
    write(32'h80, 32'h66);
    status_chk("ovf status set", 32'hE);
    write(32'h84, 32'h0);
    status_chk("ovf status cleared", 32'h6);
    do @(negedge clk); while (cyc < s + NBITS * C);
    check_frame("q22", 8'h22, 1'b0, 32'h4, lat);
    check_frame("q33", 8'h33, 1'b0, 32'h4, lat);
    check_frame("q44", 8'h44, 1'b0, 32'h4, lat);
    check_frame("q55", 8'h55, 1'b0, 32'h5, lat);
    idle_chk("ovf no sixth frame", 60);
    status_chk("ovf status final", 32'h1);

    // Decode table.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we;
      a  = vecs[i].a;
      wd = vecs[i].wd;
      #1;
      chk($sformatf("decode[%0d] sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      chk($sformatf("decode[%0d] rd", i), rd, vecs[i].exp_rd);
      if (vecs[i].we) begin
        @(posedge clk);
        #1;
        we = 1'b0;
      end
      @(negedge clk);
    end
    a = 32'h0;
    idle_chk("decode no frame", 30);
    status_chk("decode status", 32'h1);

    // Reset during data bit 3, with a second byte still queued.
    write(32'h80, 32'hC3);
    write(32'h80, 32'h5A);
    @(negedge clk);
    s = cyc;
    chk("midreset start", {31'b0, tx}, 32'h0);
    do @(negedge clk); while (cyc < s + 4 * C + 1);
    chk("midreset data bit3", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset tx", {31'b0, tx}, 32'h1);
    status_chk("midreset status", 32'h1);
    reset = 1'b0;
    idle_chk("midreset no residual", 60);
    status_chk("midreset status final", 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
